// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the MIPS datapath (PC, IM, GRF, EXT, ALU, DM).
// Each instruction is sequenced through FETCH/DECODE/EXEC/MEM/WB. For every step the
// block produces the datapath selects and write enables. DM accesses wait on mem_ready.
//
// Optional feature macro: MC_PERF_CNT_EN adds the instret/cycles performance counters.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   special    in   [5:0] opcode field of the registered IR
//   funct      in   [5:0] funct field of the registered IR
//   zero       in   ALU equality flag (used by beq)
//   mem_ready  in   DM access complete, sampled only in MEM
//   pc_we      out  PC write enable
//   pc_src     out  [1:0] 00 PC+4, 01 branch target, 10 j/jal target, 11 rs
//   ir_we      out  IR load
//   grf_we     out  GRF write enable
//   s_Wreg     out  [1:0] 00 rt, 01 rd, 10 $31
//   s_Wdata    out  [1:0] 00 ALU, 01 DM read data, 10 link
//   EXT_s      out  ALU B operand: 1 extended imm16, 0 rt
//   zero_EXT_s out  1 zero-extend imm16, 0 sign-extend
//   alu_op     out  [2:0] 000 add, 001 sub, 010 or, 011 lui
//   mem_req    out  DM access request
//   mem_we     out  DM write, meaningful only with mem_req
//   state      out  [2:0] current state (debug)
//   illegal    out  sticky unsupported-instruction flag
//   instret    out  [31:0] retired instructions (MC_PERF_CNT_EN only)
//   cycles     out  [31:0] clock count (MC_PERF_CNT_EN only)
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] special,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       ir_we,
  output logic       grf_we,
  output logic [1:0] s_Wreg,
  output logic [1:0] s_Wdata,
  output logic       EXT_s,
  output logic       zero_EXT_s,
  output logic [2:0] alu_op,
  output logic       mem_req,
  output logic       mem_we,
  output logic [2:0] state,
  output logic       illegal
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] instret,
  output logic [31:0] cycles
`endif
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic   illegal_q;

  // Instruction decode
  logic is_rtype;
  logic is_addu, is_subu, is_jr, is_nop;
  logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic is_legal;
  logic dec_done;

  always_comb begin
    is_rtype = (special == 6'b000000);
    is_addu  = is_rtype && (funct == 6'b100001);
    is_subu  = is_rtype && (funct == 6'b100011);
    is_jr    = is_rtype && (funct == 6'b001000);
    is_nop   = is_rtype && (funct == 6'b000000);
    is_ori   = (special == 6'b001101);
    is_lui   = (special == 6'b001111);
    is_lw    = (special == 6'b100011);
    is_sw    = (special == 6'b101011);
    is_beq   = (special == 6'b000100);
    is_j     = (special == 6'b000010);
    is_jal   = (special == 6'b000011);
    is_legal = is_addu | is_subu | is_jr | is_nop | is_ori | is_lui |
               is_lw | is_sw | is_beq | is_j | is_jal;
    // Instructions that complete in DECODE
    dec_done = is_j | is_jal | is_jr | is_nop | ~is_legal;
  end

  // Next-state logic
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: state_d = dec_done ? StFetch : StExec;
      StExec: begin
        if (is_addu | is_subu | is_ori | is_lui) begin
          state_d = StWb;
        end else if (is_lw | is_sw) begin
          state_d = StMem;
        end else begin
          state_d = StFetch;
        end
      end
      StMem: begin
        if (!mem_ready) begin
          state_d = StMem;
        end else if (is_lw) begin
          state_d = StWb;
        end else begin
          state_d = StFetch;
        end
      end
      StWb:    state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode && !is_legal) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // Output decode. Everything is forced low while reset is asserted so that the
  // FETCH encoding held during reset never strobes the IR or PC.
  logic [2:0] alu_op_x;
  logic       ext_x;
  logic       zext_x;

  always_comb begin
    alu_op_x = 3'b000;
    ext_x    = 1'b0;
    zext_x   = 1'b0;
    if (is_subu | is_beq) begin
      alu_op_x = 3'b001;
    end else if (is_ori) begin
      alu_op_x = 3'b010;
      ext_x    = 1'b1;
      zext_x   = 1'b1;
    end else if (is_lui) begin
      alu_op_x = 3'b011;
      ext_x    = 1'b1;
    end else if (is_lw | is_sw) begin
      ext_x    = 1'b1;
    end
  end

  always_comb begin
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    ir_we      = 1'b0;
    grf_we     = 1'b0;
    s_Wreg     = 2'b00;
    s_Wdata    = 2'b00;
    EXT_s      = 1'b0;
    zero_EXT_s = 1'b0;
    alu_op     = 3'b000;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    if (reset) begin
      case (state_q)
        StFetch: begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
        StDecode: begin
          if (is_j | is_jal) begin
            pc_we  = 1'b1;
            pc_src = 2'b10;
          end
          if (is_jal) begin
            grf_we  = 1'b1;
            s_Wreg  = 2'b10;
            s_Wdata = 2'b10;
          end
          if (is_jr) begin
            pc_we  = 1'b1;
            pc_src = 2'b11;
          end
        end
        StExec: begin
          alu_op     = alu_op_x;
          EXT_s      = ext_x;
          zero_EXT_s = zext_x;
          if (is_beq && zero) begin
            pc_we  = 1'b1;
            pc_src = 2'b01;
          end
        end
        StMem: begin
          alu_op     = alu_op_x;
          EXT_s      = ext_x;
          zero_EXT_s = zext_x;
          mem_req    = 1'b1;
          mem_we     = is_sw;
        end
        StWb: begin
          alu_op     = alu_op_x;
          EXT_s      = ext_x;
          zero_EXT_s = zext_x;
          grf_we     = 1'b1;
          s_Wreg     = (is_addu | is_subu) ? 2'b01 : 2'b00;
          s_Wdata    = is_lw ? 2'b01 : 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;

`ifdef MC_PERF_CNT_EN
  logic [31:0] instret_q, cycles_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_q <= 32'd0;
      cycles_q  <= 32'd0;
    end else begin
      cycles_q <= cycles_q + 32'd1;
      if (state_q != StFetch && state_d == StFetch) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  assign instret = instret_q;
  assign cycles  = cycles_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl. Per-cycle expected output records are queued when an
// instruction is issued and popped/compared on each falling edge.
module tb_mc_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] special;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       ir_we;
  logic       grf_we;
  logic [1:0] s_Wreg;
  logic [1:0] s_Wdata;
  logic       EXT_s;
  logic       zero_EXT_s;
  logic [2:0] alu_op;
  logic       mem_req;
  logic       mem_we;
  logic [2:0] state;
  logic       illegal;
`ifdef MC_PERF_CNT_EN
  logic [31:0] instret;
  logic [31:0] cycles;
`endif

  mc_ctrl u_dut (
    .clk        (clk),
    .reset      (reset),
    .special    (special),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .ir_we      (ir_we),
    .grf_we     (grf_we),
    .s_Wreg     (s_Wreg),
    .s_Wdata    (s_Wdata),
    .EXT_s      (EXT_s),
    .zero_EXT_s (zero_EXT_s),
    .alu_op     (alu_op),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .state      (state),
    .illegal    (illegal)
`ifdef MC_PERF_CNT_EN
    ,
    .instret    (instret),
    .cycles     (cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {state, pc_we, pc_src, ir_we, grf_we, s_Wreg, s_Wdata,
  //               EXT_s, zero_EXT_s, alu_op, mem_req, mem_we, illegal}
  typedef logic [19:0] rec_t;
  rec_t act_w;
  assign act_w = {state, pc_we, pc_src, ir_we, grf_we, s_Wreg, s_Wdata,
                  EXT_s, zero_EXT_s, alu_op, mem_req, mem_we, illegal};

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  localparam int KAddu = 0, KSubu = 1, KJr = 2, KNop = 3, KOri = 4, KLui = 5;
  localparam int KLw = 6, KSw = 7, KBeq = 8, KJ = 9, KJal = 10, KIll = 11;
  string names [12] = '{"addu", "subu", "jr", "nop", "ori", "lui",
                        "lw", "sw", "beq", "j", "jal", "ill"};

  rec_t  exp_q [$];
  bit    rdy_q [$];
  string tag_q [$];
  int    ill_exp;
  int    cyc_exp;
  int    ret_exp;

  function automatic rec_t mk(int st, int pcwe, int pcsrc, int irwe, int grfwe, int wreg,
                              int wdata, int ext, int zx, int alu, int mreq, int mwe, int ill);
    return {3'(st), 1'(pcwe), 2'(pcsrc), 1'(irwe), 1'(grfwe), 2'(wreg), 2'(wdata),
            1'(ext), 1'(zx), 3'(alu), 1'(mreq), 1'(mwe), 1'(ill)};
  endfunction

  task automatic push(input rec_t r, input bit rdy, input string t);
    exp_q.push_back(r);
    rdy_q.push_back(rdy);
    tag_q.push_back(t);
  endtask

  function automatic bit rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Queue the expected per-cycle outputs of one instruction.
  task automatic push_instr(input int k, input int z, input int nwait);
    int alu, ext, zx;
    string n;
    n = names[k];
    alu = 0; ext = 0; zx = 0;
    case (k)
      KSubu:    alu = 1;
      KOri:     begin alu = 2; ext = 1; zx = 1; end
      KLui:     begin alu = 3; ext = 1; end
      KLw, KSw: ext = 1;
      KBeq:     alu = 1;
      default:  ;
    endcase
    push(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, ill_exp), rnd_bit(), {n, ".fetch"});
    case (k)
      KJ:      push(mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, ill_exp), rnd_bit(), {n, ".dec"});
      KJal:    push(mk(1, 1, 2, 0, 1, 2, 2, 0, 0, 0, 0, 0, ill_exp), rnd_bit(), {n, ".dec"});
      KJr:     push(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, ill_exp), rnd_bit(), {n, ".dec"});
      default: push(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ill_exp), rnd_bit(), {n, ".dec"});
    endcase
    if (k == KIll) ill_exp = 1;
    if (k == KJ || k == KJal || k == KJr || k == KNop || k == KIll) return;
    if (k == KBeq) begin
      push(mk(2, z, z, 0, 0, 0, 0, ext, zx, alu, 0, 0, ill_exp), rnd_bit(), {n, ".exec"});
      return;
    end
    push(mk(2, 0, 0, 0, 0, 0, 0, ext, zx, alu, 0, 0, ill_exp), rnd_bit(), {n, ".exec"});
    if (k == KLw || k == KSw) begin
      for (int i = 0; i <= nwait; i++) begin
        push(mk(3, 0, 0, 0, 0, 0, 0, ext, zx, alu, 1, (k == KSw) ? 1 : 0, ill_exp),
             (i == nwait), $sformatf("%s.mem%0d", n, i));
      end
      if (k == KSw) return;
    end
    push(mk(4, 0, 0, 0, 1, (k == KAddu || k == KSubu) ? 1 : 0, (k == KLw) ? 1 : 0,
            ext, zx, alu, 0, 0, ill_exp), rnd_bit(), {n, ".wb"});
  endtask

  // Called just after a rising edge; checks each cycle on the falling edge.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      check_val(tag_q.pop_front(), 32'(act_w), 32'(exp_q.pop_front()));
`ifdef MC_PERF_CNT_EN
      check_val("cycles", cycles, 32'(cyc_exp));
`endif
      @(posedge clk);
      #1;
      cyc_exp++;
    end
  endtask

  task automatic set_fields(input int k);
    funct = 6'($urandom_range(0, 63));
    case (k)
      KAddu: begin special = 6'b000000; funct = 6'b100001; end
      KSubu: begin special = 6'b000000; funct = 6'b100011; end
      KJr:   begin special = 6'b000000; funct = 6'b001000; end
      KNop:  begin special = 6'b000000; funct = 6'b000000; end
      KOri:  special = 6'b001101;
      KLui:  special = 6'b001111;
      KLw:   special = 6'b100011;
      KSw:   special = 6'b101011;
      KBeq:  special = 6'b000100;
      KJ:    special = 6'b000010;
      KJal:  special = 6'b000011;
      default: special = 6'b111111;
    endcase
  endtask

  task automatic run_instr(input int k, input int z, input int nwait);
    set_fields(k);
    zero = z[0];
`ifdef MC_PERF_CNT_EN
    check_val("instret", instret, 32'(ret_exp));
`endif
    push_instr(k, z, nwait);
    run_cycles(exp_q.size());
    ret_exp++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    special   = 6'd0;
    funct     = 6'd0;
    zero      = 1'b0;
    mem_ready = 1'b1;
    ill_exp   = 0;
    cyc_exp   = 0;
    ret_exp   = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_outputs", 32'(act_w), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_instr(KOri, 0, 0);
    run_instr(KLw, 0, 3);
    run_instr(KBeq, 1, 0);
    run_instr(KBeq, 0, 0);
    run_instr(KJal, 1, 0);
    run_instr(KJ, 0, 0);
    run_instr(KJr, 1, 0);
    run_instr(KNop, 0, 0);
    run_instr(KSubu, 1, 0);
    run_instr(KLui, 0, 0);
    run_instr(KSw, 1, 0);
    run_instr(KSw, 0, 2);
    run_instr(KAddu, 0, 0);
    run_instr(KLw, 0, 0);
    run_instr(KIll, 0, 0);
    run_instr(KAddu, 1, 0);

    // sw interrupted by reset while waiting in MEM
    set_fields(KSw);
    push_instr(KSw, 0, 5);
    run_cycles(4);
    #2;
    reset = 1'b0;
    #1;
    check_val("rst_mem_req", 32'(mem_req), 32'd0);
    check_val("rst_mem_we", 32'(mem_we), 32'd0);
    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_illegal", 32'(illegal), 32'd0);
`ifdef MC_PERF_CNT_EN
    check_val("rst_instret", instret, 32'd0);
    check_val("rst_cycles", cycles, 32'd0);
`endif
    exp_q.delete();
    rdy_q.delete();
    tag_q.delete();
    ill_exp = 0;
    @(negedge clk);
    check_val("rst_hold", 32'(act_w), 32'd0);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    cyc_exp = 0;
    ret_exp = 0;
    run_instr(KAddu, 0, 0);
    @(negedge clk);
    check_val("final_state", 32'(state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
